req_conditioner: RTL and testbench

Upstream request conditioner for the two-channel grant FSM. It turns single-cycle request events into level `req` lines held until serviced and queues back-to-back events in per-channel pending counters. It enforces a release gap after each grant and abandons requests that go ungranted for `TIMEOUT` cycles. Its `req[1:0]` output drives the FSM's `req` input directly, and the FSM's `gnt[1:0]` feeds back into it.

---
 rtl/req_conditioner.sv | 129 ++++++++++++
 tb/tb_req_conditioner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/req_conditioner.sv
// req_conditioner
//   Per-channel request conditioner in front of the two-channel grant FSM.
//   Single-cycle events are queued in a pending counter and presented as a
//   level request. Each request is held until it is granted or until it has
//   waited TIMEOUT cycles, in which case it is dropped. A release gap is
//   enforced after every grant.
//
// Ports
//   clock      : rising-edge clock
//   reset      : asynchronous active-high reset, clears all state
//   evt[1:0]   : one-cycle request event per channel
//   gnt[1:0]   : grant level from the arbiter FSM
//   req[1:0]   : registered request level to the arbiter
//   pending0   : channel 0 queued-event count
//   pending1   : channel 1 queued-event count
//   overflow   : one-cycle pulse, event lost because the counter was full
//   drop       : one-cycle pulse, request abandoned after TIMEOUT cycles
//   drop_count : total drops, saturating at 255
module req_conditioner #(
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       evt,
  input  logic [1:0]       gnt,
  output logic [1:0]       req,
  output logic [CNT_W-1:0] pending0,
  output logic [CNT_W-1:0] pending1,
  output logic [1:0]       overflow,
  output logic [1:0]       drop,
  output logic [7:0]       drop_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [7:0]       T_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] P_MAX  = '1;

  state_t           state [2];
  logic [7:0]       timer [2];
  logic [CNT_W-1:0] pend  [2];

  logic [1:0] svc;   // grant accepted this cycle
  logic [1:0] tmo;   // timeout expires this cycle
  logic [1:0] dec;
  logic [1:0] ovf;
  logic [8:0] dc_sum;

  always_comb begin
    svc = '0;
    tmo = '0;
    ovf = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (state[i] == REQ) begin
        // A grant arriving on the last timer cycle wins over the timeout.
        svc[i] = gnt[i];
        tmo[i] = ~gnt[i] & (timer[i] == T_LAST);
      end
      // A simultaneous decrement makes room, so only an undisturbed full
      // counter loses the event.
      ovf[i] = evt[i] & ~(svc[i] | tmo[i]) & (pend[i] == P_MAX);
    end
  end

  assign dec    = svc | tmo;
  assign dc_sum = {1'b0, drop_count} + {8'd0, tmo[0]} + {8'd0, tmo[1]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        state[i] <= IDLE;
        timer[i] <= '0;
        pend[i]  <= '0;
      end
      req        <= '0;
      overflow   <= '0;
      drop       <= '0;
      drop_count <= '0;
    end else begin
      overflow   <= ovf;
      drop       <= tmo;
      drop_count <= dc_sum[8] ? 8'hFF : dc_sum[7:0];
      for (int unsigned i = 0; i < 2; i++) begin
        if (evt[i] && !dec[i] && pend[i] != P_MAX)
          pend[i] <= pend[i] + 1'b1;
        else if (!evt[i] && dec[i] && pend[i] != '0)
          pend[i] <= pend[i] - 1'b1;

        case (state[i])
          IDLE: begin
            if (evt[i] || pend[i] != '0) begin
              state[i] <= REQ;
              timer[i] <= '0;
              req[i]   <= 1'b1;
            end
          end
          REQ: begin
            if (gnt[i]) begin
              state[i] <= HOLD;
              req[i]   <= 1'b0;
            end else if (timer[i] == T_LAST) begin
              state[i] <= IDLE;
              req[i]   <= 1'b0;
            end else begin
              timer[i] <= timer[i] + 8'd1;
            end
          end
          HOLD: begin
            if (!gnt[i])
              state[i] <= IDLE;
          end
          default: begin
            state[i] <= IDLE;
            req[i]   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pending0 = pend[0];
  assign pending1 = pend[1];

endmodule

// File: tb/tb_req_conditioner.sv
module tb_req_conditioner;

  typedef struct packed {
    logic [1:0] req;
    logic [2:0] p0;
    logic [2:0] p1;
    logic [1:0] ovf;
    logic [1:0] drp;
    logic [7:0] dc;
  } obs_t;

  typedef struct {
    logic       rst;
    logic [1:0] evt;
    logic [1:0] gnt;
    obs_t       exp;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] evt, gnt, evt_s, gnt_s;
  logic [1:0] req, overflow, drop;
  logic [2:0] pending0, pending1;
  logic [7:0] drop_count;
  logic [1:0] req_s, overflow_s, drop_s;
  logic [2:0] pending0_s, pending1_s;
  logic [7:0] drop_count_s;

  int errors = 0;
  int checks = 0;

  vec_t vecs[$];
  obs_t sb[$];

  obs_t act_m, act_s;
  assign act_m = {req, pending0, pending1, overflow, drop, drop_count};
  // Saturation instance: only req, drop and drop_count are predicted.
  assign act_s = {req_s, 3'd0, 3'd0, 2'b00, drop_s, drop_count_s};

  always #5 clock = ~clock;

  req_conditioner #(.CNT_W(3), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .evt(evt), .gnt(gnt), .req(req),
    .pending0(pending0), .pending1(pending1), .overflow(overflow),
    .drop(drop), .drop_count(drop_count)
  );

  req_conditioner #(.CNT_W(3), .TIMEOUT(4)) u_sat (
    .clock(clock), .reset(reset), .evt(evt_s), .gnt(gnt_s), .req(req_s),
    .pending0(pending0_s), .pending1(pending1_s), .overflow(overflow_s),
    .drop(drop_s), .drop_count(drop_count_s)
  );

  function automatic obs_t o(input logic [1:0] r, input logic [2:0] p0,
                             input logic [2:0] p1, input logic [1:0] ov,
                             input logic [1:0] dr, input logic [7:0] dc);
    o = {r, p0, p1, ov, dr, dc};
  endfunction

  function automatic void add(input logic r, input logic [1:0] e,
                              input logic [1:0] g, input obs_t x);
    vec_t v;
    v.rst = r; v.evt = e; v.gnt = g; v.exp = x;
    vecs.push_back(v);
  endfunction

  task automatic compare(input string tag, input obs_t act);
    obs_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", tag, act);
    end else begin
      e = sb.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got req=%b p0=%0d p1=%0d ovf=%b drop=%b dc=%0d, expected req=%b p0=%0d p1=%0d ovf=%b drop=%b dc=%0d",
                 tag, act.req, act.p0, act.p1, act.ovf, act.drp, act.dc,
                 e.req, e.p0, e.p1, e.ovf, e.drp, e.dc);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    obs_t z;
    int   k, dcx;
    z = o(2'b00, 3'd0, 3'd0, 2'b00, 2'b00, 8'd0);
    reset = 1'b1; evt = '0; gnt = '0; evt_s = '0; gnt_s = '0;

    // Single ch0 request, grant, release
    add(1, 2'b00, 2'b00, z);
    add(0, 2'b00, 2'b00, z);
    add(0, 2'b01, 2'b00, o(2'b01, 3'd1, 3'd0, 2'b00, 2'b00, 8'd0));
    add(0, 2'b00, 2'b00, o(2'b01, 3'd1, 3'd0, 2'b00, 2'b00, 8'd0));
    add(0, 2'b00, 2'b01, z);
    add(0, 2'b00, 2'b01, z);
    add(0, 2'b00, 2'b00, z);
    add(0, 2'b00, 2'b00, z);
    // Two queued events: re-request gap after first grant
    add(0, 2'b01, 2'b00, o(2'b01, 3'd1, 3'd0, 2'b00, 2'b00, 8'd0));
    add(0, 2'b01, 2'b00, o(2'b01, 3'd2, 3'd0, 2'b00, 2'b00, 8'd0));
    add(0, 2'b00, 2'b01, o(2'b00, 3'd1, 3'd0, 2'b00, 2'b00, 8'd0));
    add(0, 2'b00, 2'b00, o(2'b00, 3'd1, 3'd0, 2'b00, 2'b00, 8'd0));
    add(0, 2'b00, 2'b00, o(2'b01, 3'd1, 3'd0, 2'b00, 2'b00, 8'd0));
    add(0, 2'b00, 2'b01, z);
    add(0, 2'b00, 2'b00, z);
    add(0, 2'b00, 2'b00, z);
    // Fill ch0 to 7, event together with service, event at max in HOLD
    for (int i = 1; i <= 7; i++)
      add(0, 2'b01, 2'b00, o(2'b01, 3'(i), 3'd0, 2'b00, 2'b00, 8'd0));
    add(0, 2'b01, 2'b01, o(2'b00, 3'd7, 3'd0, 2'b00, 2'b00, 8'd0));
    add(0, 2'b01, 2'b01, o(2'b00, 3'd7, 3'd0, 2'b01, 2'b00, 8'd0));
    add(0, 2'b00, 2'b00, o(2'b00, 3'd7, 3'd0, 2'b00, 2'b00, 8'd0));
    add(0, 2'b00, 2'b00, o(2'b01, 3'd7, 3'd0, 2'b00, 2'b00, 8'd0));
    add(1, 2'b00, 2'b00, z);
    // Grant in the 16th req cycle beats the timeout
    add(0, 2'b01, 2'b00, o(2'b01, 3'd1, 3'd0, 2'b00, 2'b00, 8'd0));
    for (int i = 0; i < 15; i++)
      add(0, 2'b00, 2'b00, o(2'b01, 3'd1, 3'd0, 2'b00, 2'b00, 8'd0));
    add(0, 2'b00, 2'b01, z);
    add(0, 2'b00, 2'b00, z);
    add(0, 2'b00, 2'b00, z);
    add(1, 2'b00, 2'b00, z);
    // Burst of 9 ch1 events, overflow on 8th/9th, then timeout
    for (int i = 1; i <= 9; i++)
      add(0, 2'b10, 2'b00, o(2'b10, 3'd0, 3'((i > 7) ? 7 : i),
                             (i >= 8) ? 2'b10 : 2'b00, 2'b00, 8'd0));
    for (int i = 10; i <= 16; i++)
      add(0, 2'b00, 2'b00, o(2'b10, 3'd0, 3'd7, 2'b00, 2'b00, 8'd0));
    add(0, 2'b00, 2'b00, o(2'b00, 3'd0, 3'd6, 2'b00, 2'b10, 8'd1));
    add(0, 2'b00, 2'b00, o(2'b10, 3'd0, 3'd6, 2'b00, 2'b00, 8'd1));

    repeat (2) @(posedge clock);
    #1;
    sb.push_back(z);
    compare("reset_state", act_m);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      evt   = vecs[i].evt;
      gnt   = vecs[i].gnt;
      sb.push_back(vecs[i].exp);
      @(posedge clock);
      #1;
      compare($sformatf("vec%0d", i), act_m);
    end

    // Asynchronous reset mid-REQ on ch1 (pending and drop_count nonzero)
    evt = '0; gnt = '0;
    #2;
    reset = 1'b1;
    #1;
    sb.push_back(z);
    compare("async_reset", act_m);
    @(posedge clock);
    #1;
    sb.push_back(z);
    compare("reset_hold", act_m);
    reset = 1'b0;
    sb.push_back(z);
    @(posedge clock);
    #1;
    compare("post_reset_idle", act_m);

    // TIMEOUT=4 instance, both channels requesting without grant:
    // drops on both every 5th edge, drop_count saturates at 255.
    evt_s = 2'b11;
    for (int n = 1; n <= 660; n++) begin
      k   = n % 5;
      dcx = 2 * (n / 5);
      if (dcx > 255) dcx = 255;
      sb.push_back(o((k == 0) ? 2'b00 : 2'b11, 3'd0, 3'd0, 2'b00,
                     (k == 0) ? 2'b11 : 2'b00, 8'(dcx)));
      @(posedge clock);
      #1;
      compare($sformatf("sat_edge%0d", n), act_s);
    end
    evt_s = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
